// File: rtl/display_pkg.sv
// Shared definitions for the display pixel streamer: FSM state codes, pixel bus width and colour-bar palette.
package display_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT_SOF   = 2'd0;
    localparam state_t ST_WAIT_LEVEL = 2'd1;
    localparam state_t ST_STREAM     = 2'd2;
    localparam state_t ST_FLUSH      = 2'd3;

    function automatic int unsigned pix_width(input int unsigned ppc, input int unsigned bpc);
        return ppc * 3 * bpc;
    endfunction

    // Bar colours as {B,G,R} on/off flags, left to right.
    function automatic logic [2:0] bar_colour(input int unsigned idx);
        case (idx)
            0:       return 3'b111;
            1:       return 3'b011;
            2:       return 3'b110;
            3:       return 3'b010;
            4:       return 3'b101;
            5:       return 3'b001;
            6:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/display_pixel_streamer_if.sv
// Input pixel stream handshake: SOF-tagged pixel beats from DMA to the streamer.
interface display_pixel_streamer_if #(
    parameter int unsigned DATA_W = 48
) ();

    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tuser;
    logic              s_tready;

    modport master (output s_tdata, output s_tvalid, output s_tuser, input  s_tready);
    modport slave  (input  s_tdata, input  s_tvalid, input  s_tuser, output s_tready);

endinterface

// File: rtl/display_fwft_fifo.sv
// Synchronous show-ahead FIFO: head entry is always visible on o_rd_data; o_level reports occupancy.
module display_fwft_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    assign w_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_wr      = i_wr_en & ~w_full;
    assign w_rd      = i_rd_en & ~o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/display_pixel_streamer.sv
// Buffers an SOF-tagged DMA pixel stream and plays it out against parametrised video timing.
// Optional pattern generator enabled by defining DISPLAY_TEST_PATTERN_EN.
module display_pixel_streamer
    import display_pkg::*;
#(
    parameter int unsigned PPC          = 2,
    parameter int unsigned BPC          = 8,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 55,
    parameter int unsigned H_SYNC       = 20,
    parameter int unsigned H_BP         = 110,
    parameter int unsigned V_ACTIVE     = 720,
    parameter int unsigned V_FP         = 5,
    parameter int unsigned V_SYNC       = 5,
    parameter int unsigned V_BP         = 20,
    parameter logic        HS_POL       = 1'b0,
    parameter logic        VS_POL       = 1'b0,
    parameter int unsigned FIFO_DEPTH   = 1024,
    parameter int unsigned START_LEVEL  = 512,
    parameter int unsigned AFULL_MARGIN = 10,
    localparam int unsigned PW          = pix_width(PPC, BPC),
    localparam int unsigned LW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    lvds_slowclk,
    input  logic                    rst,
    display_pixel_streamer_if.slave s_axis,
`ifdef DISPLAY_TEST_PATTERN_EN
    input  logic                    tp_enable,
    input  logic [1:0]              tp_select,
`endif
    output logic [PW-1:0]           out_data,
    output logic                    out_de,
    output logic                    out_hsync,
    output logic                    out_vsync,
    output logic                    out_sof,
    output logic                    underflow_sticky,
    output logic [15:0]             frame_count,
    output logic [15:0]             resync_count,
    output logic [LW-1:0]           fifo_level
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HW      = $clog2(H_TOTAL + 1);
    localparam int unsigned VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_HI = HW'(H_SYNC);
    localparam logic [HW-1:0] H_DE_LO   = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_DE_HI   = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_HI = VW'(V_SYNC);
    localparam logic [VW-1:0] V_DE_LO   = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_DE_HI   = VW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [LW-1:0] L_START   = LW'(START_LEVEL);
    localparam logic [LW-1:0] L_AFULL   = LW'(FIFO_DEPTH - AFULL_MARGIN);

    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_first;
    logic          r_tready;
    logic [PW-1:0] r_data;
    logic          r_de;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_sof;
    logic          r_sticky;
    logic [15:0]   r_frames;
    logic [15:0]   r_resyncs;

    logic          w_de;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_boundary;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [PW:0]   w_head;
    logic          w_head_sof;
    logic [LW-1:0] w_level;
    logic          w_emit;
    logic          w_resync;
    logic          w_underflow;
    logic          w_frame_start;
    logic [PW-1:0] w_data_nxt;

    assign w_de       = (r_hcount >= H_DE_LO) && (r_hcount < H_DE_HI) &&
                        (r_vcount >= V_DE_LO) && (r_vcount < V_DE_HI);
    assign w_hs_act   = (r_hcount < H_SYNC_HI);
    assign w_vs_act   = (r_vcount < V_SYNC_HI);
    assign w_boundary = (r_hcount == '0) && (r_vcount == '0);
    assign w_push     = s_axis.s_tvalid & r_tready;
    assign w_head_sof = w_head[PW];

    assign s_axis.s_tready = r_tready;

    display_fwft_fifo #(
        .WIDTH (PW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (lvds_slowclk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data ({s_axis.s_tuser, s_axis.s_tdata}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    always_ff @(posedge lvds_slowclk) begin
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (r_hcount == H_LAST) begin
            r_hcount <= '0;
            r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + VW'(1);
        end else begin
            r_hcount <= r_hcount + HW'(1);
        end
    end

    // Frame-sync decisions are taken on DE cycles only; every failure path drops to black until re-aligned.
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_emit        = 1'b0;
        w_resync      = 1'b0;
        w_underflow   = 1'b0;
        w_frame_start = 1'b0;
        case (r_state)
            ST_WAIT_SOF, ST_FLUSH: begin
                if (!w_empty) begin
                    if (w_head_sof) w_state_nxt = ST_WAIT_LEVEL;
                    else            w_pop       = 1'b1;
                end
            end
            ST_WAIT_LEVEL: begin
                if (w_boundary && (w_level >= L_START)) begin
                    w_state_nxt   = ST_STREAM;
                    w_frame_start = 1'b1;
                end
            end
            ST_STREAM: begin
                if (w_boundary) begin
                    w_frame_start = 1'b1;
                end else if (w_de) begin
                    if (w_empty) begin
                        w_underflow = 1'b1;
                        w_resync    = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end else if (r_first && !w_head_sof) begin
                        w_resync    = 1'b1;
                        w_state_nxt = ST_WAIT_SOF;
                    end else if (!r_first && w_head_sof) begin
                        w_resync    = 1'b1;
                        w_state_nxt = ST_WAIT_LEVEL;
                    end else begin
                        w_pop  = 1'b1;
                        w_emit = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_WAIT_SOF;
        endcase
    end

`ifdef DISPLAY_TEST_PATTERN_EN
    localparam int unsigned BAR_W = (H_ACTIVE * PPC / 8 > 0) ? H_ACTIVE * PPC / 8 : 1;

    function automatic logic [PW-1:0] tp_pixels(input logic [1:0] sel, input int unsigned x0,
                                                input int unsigned y);
        logic [PW-1:0] px;
        logic [2:0]    c;
        int unsigned   x;
        int unsigned   bar;
        px = '0;
        for (int unsigned p = 0; p < PPC; p++) begin
            x   = x0 + p;
            bar = x / BAR_W;
            case (sel)
                2'd0:    c = bar_colour((bar > 7) ? 7 : bar);
                2'd1:    c = 3'b000;
                2'd2:    c = 3'b111;
                default: c = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 3'b111 : 3'b000;
            endcase
            px[p*3*BPC +: 3*BPC] = {{BPC{c[2]}}, {BPC{c[1]}}, {BPC{c[0]}}};
            if (sel == 2'd1) px[p*3*BPC +: BPC] = BPC'(x);
        end
        return px;
    endfunction

    logic [PW-1:0] w_tp_data;
    always_comb begin
        w_tp_data = tp_pixels(tp_select, (32'(r_hcount) - (H_SYNC + H_BP)) * PPC,
                              32'(r_vcount) - (V_SYNC + V_BP));
    end
`endif

    always_comb begin
        w_data_nxt = w_emit ? w_head[PW-1:0] : '0;
`ifdef DISPLAY_TEST_PATTERN_EN
        if (tp_enable && w_de) w_data_nxt = w_tp_data;
`endif
    end

    always_ff @(posedge lvds_slowclk) begin
        if (rst) begin
            r_state   <= ST_WAIT_SOF;
            r_first   <= 1'b0;
            r_tready  <= 1'b0;
            r_data    <= '0;
            r_de      <= 1'b0;
            r_hsync   <= ~HS_POL;
            r_vsync   <= ~VS_POL;
            r_sof     <= 1'b0;
            r_sticky  <= 1'b0;
            r_frames  <= '0;
            r_resyncs <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tready <= (w_level < L_AFULL);
            r_data   <= w_data_nxt;
            r_de     <= w_de;
            r_hsync  <= w_hs_act ? HS_POL : ~HS_POL;
            r_vsync  <= w_vs_act ? VS_POL : ~VS_POL;
            r_sof    <= w_emit & r_first;
            if (w_frame_start)                     r_first <= 1'b1;
            else if (r_state == ST_STREAM && w_de) r_first <= 1'b0;
            if (w_underflow)   r_sticky  <= 1'b1;
            if (w_frame_start) r_frames  <= r_frames + 16'd1;
            if (w_resync)      r_resyncs <= r_resyncs + 16'd1;
        end
    end

    assign out_data         = r_data;
    assign out_de           = r_de;
    assign out_hsync        = r_hsync;
    assign out_vsync        = r_vsync;
    assign out_sof          = r_sof;
    assign underflow_sticky = r_sticky;
    assign frame_count      = r_frames;
    assign resync_count     = r_resyncs;
    assign fifo_level       = w_level;

endmodule

// File: tb/tb_display_pixel_streamer.sv
// Scoreboard bench: a queue-based reference model predicts every output cycle; a monitor compares on the falling edge.
module tb_display_pixel_streamer;

    localparam int unsigned PW = 48;

    typedef struct packed {
        logic          sof;
        logic [PW-1:0] px;
    } beat_t;

    typedef struct packed {
        logic          de;
        logic          hs;
        logic          vs;
        logic          sof;
        logic          rdy;
        logic          stk;
        logic [PW-1:0] data;
        logic [4:0]    lvl;
        logic [15:0]   frames;
        logic [15:0]   resyncs;
    } obs_t;

    typedef enum {M_HUNT, M_ARM, M_PLAY, M_DRAIN} mode_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] out_data;
    logic          out_de, out_hsync, out_vsync, out_sof, underflow_sticky;
    logic [15:0]   frame_count, resync_count;
    logic [4:0]    fifo_level;

    display_pixel_streamer_if #(.DATA_W(PW)) bus ();

    display_pixel_streamer #(
        .PPC(2), .BPC(8),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .FIFO_DEPTH(16), .START_LEVEL(8), .AFULL_MARGIN(2)
    ) dut (
        .lvds_slowclk     (clk),
        .rst              (rst),
        .s_axis           (bus),
        .out_data         (out_data),
        .out_de           (out_de),
        .out_hsync        (out_hsync),
        .out_vsync        (out_vsync),
        .out_sof          (out_sof),
        .underflow_sticky (underflow_sticky),
        .frame_count      (frame_count),
        .resync_count     (resync_count),
        .fifo_level       (fifo_level)
    );

    initial forever #5 clk = ~clk;

    beat_t       src_q[$];
    beat_t       fifo_m[$];
    obs_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    bit          gappy = 1'b0;
    logic        acc   = 1'b0;

    // Reference model: video position from elapsed cycles, buffer as a plain queue.
    initial begin
        int unsigned n;
        int unsigned hc, vc;
        mode_t       mode;
        logic        m_ready, sticky, first_px, active, nxt_ready, sofp;
        logic [15:0] frames, resyncs;
        logic [PW-1:0] px;
        beat_t       b;
        obs_t        e;
        n = 0; mode = M_HUNT; m_ready = 0; sticky = 0; first_px = 0;
        frames = 0; resyncs = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                fifo_m.delete();
                mode = M_HUNT; n = 0; m_ready = 0; sticky = 0; first_px = 0;
                frames = 0; resyncs = 0; acc = 0;
                e = '{de: 1'b0, hs: 1'b1, vs: 1'b1, sof: 1'b0, rdy: 1'b0, stk: 1'b0,
                      data: '0, lvl: 5'd0, frames: 16'd0, resyncs: 16'd0};
            end else begin
                hc = n % 14;
                vc = (n / 14) % 7;
                active = (hc >= 4) && (hc < 12) && (vc >= 2) && (vc < 6);
                acc = bus.s_tvalid && m_ready;
                nxt_ready = (fifo_m.size() < 14);
                px = '0; sofp = 0;
                case (mode)
                    M_HUNT, M_DRAIN: begin
                        if (fifo_m.size() > 0) begin
                            if (fifo_m[0].sof) mode = M_ARM;
                            else               void'(fifo_m.pop_front());
                        end
                    end
                    M_ARM: begin
                        if (hc == 0 && vc == 0 && fifo_m.size() >= 8) begin
                            mode = M_PLAY; frames++; first_px = 1;
                        end
                    end
                    M_PLAY: begin
                        if (hc == 0 && vc == 0) begin
                            frames++; first_px = 1;
                        end else if (active) begin
                            if (fifo_m.size() == 0) begin
                                sticky = 1; resyncs++; mode = M_DRAIN;
                            end else if (first_px && !fifo_m[0].sof) begin
                                resyncs++; mode = M_HUNT;
                            end else if (!first_px && fifo_m[0].sof) begin
                                resyncs++; mode = M_ARM;
                            end else begin
                                b = fifo_m.pop_front(); px = b.px; sofp = first_px;
                            end
                            first_px = 0;
                        end
                    end
                    default: mode = M_HUNT;
                endcase
                if (acc) fifo_m.push_back('{sof: bus.s_tuser, px: bus.s_tdata});
                m_ready = nxt_ready;
                n++;
                e = '{de: active, hs: (hc >= 2), vs: (vc >= 1), sof: sofp, rdy: m_ready,
                      stk: sticky, data: px, lvl: 5'(fifo_m.size()), frames: frames,
                      resyncs: resyncs};
            end
            exp_q.push_back(e);
        end
    end

    // Driver: present the head of the source queue; retire it once accepted.
    initial forever begin
        @(negedge clk);
        if (acc && src_q.size() > 0) void'(src_q.pop_front());
        if (!rst && src_q.size() > 0 && (!gappy || $urandom_range(0, 3) != 0)) begin
            bus.s_tvalid = 1'b1;
            bus.s_tuser  = src_q[0].sof;
            bus.s_tdata  = src_q[0].px;
        end else begin
            bus.s_tvalid = 1'b0;
            bus.s_tuser  = 1'b0;
            bus.s_tdata  = '0;
        end
    end

    // Monitor
    initial forever begin
        obs_t e, a;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{de: out_de, hs: out_hsync, vs: out_vsync, sof: out_sof, rdy: bus.s_tready,
                  stk: underflow_sticky, data: out_data, lvl: fifo_level,
                  frames: frame_count, resyncs: resync_count};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle @%0t: got de=%b hs=%b vs=%b sof=%b rdy=%b stk=%b data=%h lvl=%0d frm=%0d rsy=%0d, expected de=%b hs=%b vs=%b sof=%b rdy=%b stk=%b data=%h lvl=%0d frm=%0d rsy=%0d",
                         $time, a.de, a.hs, a.vs, a.sof, a.rdy, a.stk, a.data, a.lvl, a.frames, a.resyncs,
                         e.de, e.hs, e.vs, e.sof, e.rdy, e.stk, e.data, e.lvl, e.frames, e.resyncs);
            end
            tests++;
            if (fifo_level > 5'd16) begin
                fails++;
                $display("FAIL level_bound: got %0d, required <= 16", fifo_level);
            end
        end
    end

    task automatic add_frame(input int unsigned nbeats, input bit with_sof);
        beat_t b;
        for (int unsigned i = 0; i < nbeats; i++) begin
            b.sof        = with_sof && (i == 0);
            b.px[31:0]   = $urandom();
            b.px[47:32]  = 16'($urandom());
            src_q.push_back(b);
        end
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.s_tvalid = 1'b0;
        bus.s_tuser  = 1'b0;
        bus.s_tdata  = '0;
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2 * 98);                  // free-running timing, no data
        add_frame(32, 1'b1);                  // one full frame
        wait_cycles(3 * 98);
        add_frame(32, 1'b1);                  // back-to-back frames
        add_frame(32, 1'b1);
        wait_cycles(4 * 98);
        add_frame(20, 1'b1);                  // short frame then a gap: underflow
        wait_cycles(3 * 98);
        add_frame(32, 1'b1);
        wait_cycles(3 * 98);
        add_frame(5, 1'b0);                   // garbage ahead of SOF
        add_frame(32, 1'b1);
        wait_cycles(3 * 98);
        add_frame(12, 1'b1);                  // early SOF at beat 12
        add_frame(32, 1'b1);
        wait_cycles(4 * 98);
        add_frame(32, 1'b1);                  // reset in the middle of streaming
        add_frame(32, 1'b1);
        wait_cycles(2 * 98 + 40);
        rst = 1'b1;
        src_q.delete();
        bus.s_tvalid = 1'b0;
        wait_cycles(2);
        rst = 1'b0;
        gappy = 1'b1;                         // random valid gaps
        for (int i = 0; i < 4; i++) add_frame(32, 1'b1);
        add_frame(3, 1'b0);
        add_frame(32, 1'b1);
        wait_cycles(8 * 98);
        gappy = 1'b0;
        wait_cycles(2);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
